// File: rtl/jserial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package jserial_add_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/jserial_add_jadd.sv
// Gate-level one-bit full adder cell used by the serial adder datapath.
module jadd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p, g, t;

  xor u_xp (p, a, b);
  xor u_xs (s, p, ci);
  and u_ag (g, a, b);
  and u_at (t, p, ci);
  or  u_oc (co, g, t);

endmodule

// File: rtl/jserial_add.sv
// Bit-serial adder: wa+wb+wci one bit per cycle through a single jadd cell, LSB first.
// Optional unsigned compare outputs (weqo/walo) are built when JSERIAL_CMP_EN is defined.
module jserial_add
  import jserial_add_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] wa,
  input  logic [N-1:0] wb,
  input  logic         wci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] wc,
  output logic         wco
`ifdef JSERIAL_CMP_EN
  ,
  output logic         weqo,
  output logic         walo
`endif
);

  localparam int unsigned CW = cnt_width(N);

  state_t        state;
  logic [N-1:0]  sa, sb, sr;
  logic [CW-1:0] cnt;
  logic          cf, s, co, accept, last;
  logic [N-1:0]  sr_next;

`ifdef JSERIAL_CMP_EN
  logic eq, gt, diff;
  assign diff = sa[0] ^ sb[0];
`endif

  jadd u_jadd (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (cf),
    .s  (s),
    .co (co)
  );

  assign accept  = start && (state == ST_IDLE || state == ST_DONE);
  assign last    = (cnt == CW'(N - 1));
  // Sum bit enters at the MSB; after N shifts bit 0 of the sum sits at the LSB.
  assign sr_next = N'({s, sr} >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      wc    <= '0;
      wco   <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      cf    <= 1'b0;
      cnt   <= '0;
`ifdef JSERIAL_CMP_EN
      eq    <= 1'b0;
      gt    <= 1'b0;
      weqo  <= 1'b0;
      walo  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        state <= ST_RUN;
        busy  <= 1'b1;
        sa    <= wa;
        sb    <= wb;
        cf    <= wci;
        cnt   <= '0;
        sr    <= '0;
        wc    <= '0;
        wco   <= 1'b0;
`ifdef JSERIAL_CMP_EN
        eq    <= 1'b1;
        gt    <= 1'b0;
        weqo  <= 1'b0;
        walo  <= 1'b0;
`endif
      end else begin
        case (state)
          ST_RUN: begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= sr_next;
            cf  <= co;
            cnt <= cnt + CW'(1);
`ifdef JSERIAL_CMP_EN
            eq  <= eq & ~diff;
            if (diff) gt <= sa[0];
`endif
            if (last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              wc    <= sr_next;
              wco   <= co;
`ifdef JSERIAL_CMP_EN
              // Publish this cycle's updated compare values alongside the sum.
              weqo  <= eq & ~diff;
              walo  <= diff ? sa[0] : gt;
`endif
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jserial_add.sv
// Self-checking bench for jserial_add (N=8) against an arithmetic reference model.
module tb_jserial_add;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset, start, wci;
  logic [N-1:0] wa, wb, wc;
  logic         busy, done, wco;
`ifdef JSERIAL_CMP_EN
  logic         weqo, walo;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  jserial_add #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .wa    (wa),
    .wb    (wb),
    .wci   (wci),
    .busy  (busy),
    .done  (done),
    .wc    (wc),
    .wco   (wco)
`ifdef JSERIAL_CMP_EN
    ,
    .weqo  (weqo),
    .walo  (walo)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic ci);
    logic [N:0] ref_sum;
    ref_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    check({tag, "_wc"},  64'(wc),  64'(ref_sum[N-1:0]));
    check({tag, "_wco"}, 64'(wco), 64'(ref_sum[N]));
`ifdef JSERIAL_CMP_EN
    check({tag, "_weqo"}, 64'(weqo), 64'(a == b));
    check({tag, "_walo"}, 64'(walo), 64'(a > b));
`endif
  endtask

  // Called in the first cycle after an accepted start; returns in the done cycle.
  task automatic wait_done(input int unsigned poke_at, output int unsigned at,
                           output int unsigned busy_n, output logic early);
    at = 0;
    busy_n = 0;
    early = 1'b0;
    for (int unsigned cyc = 1; cyc <= 4 * N; cyc++) begin
      if (done) begin
        at = cyc;
        break;
      end
      if (busy) busy_n++;
      if (wc != '0 || wco) early = 1'b1;
      if (poke_at != 0 && cyc == poke_at) begin
        start = 1'b1;
        wa    = N'($urandom);
        wb    = N'($urandom);
        wci   = 1'($urandom);
      end
      if (poke_at != 0 && cyc == poke_at + 1) start = 1'b0;
      tick();
    end
  endtask

  task automatic check_timing(input string tag, input int unsigned at,
                              input int unsigned busy_n, input logic early);
    check({tag, "_latency"}, 64'(at), 64'(N + 1));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(N));
    check({tag, "_early_result"}, 64'(early), 64'(0));
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci, input int unsigned poke_at);
    int unsigned at, busy_n, extra;
    logic early;
    wa = a; wb = b; wci = ci; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(poke_at, at, busy_n, early);
    check_timing(tag, at, busy_n, early);
    check_result(tag, a, b, ci);
    tick();
    check({tag, "_done_width"}, 64'(done), 64'(0));
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    check_result({tag, "_hold"}, a, b, ci);
    extra = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      if (done) extra++;
    end
    check({tag, "_extra_done"}, 64'(extra), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] a1, b1, a2, b2;
    logic         c1, c2;
    int unsigned  at, busy_n, extra;
    logic         early;

    reset = 1'b1; start = 1'b0; wa = '0; wb = '0; wci = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_wc",   64'(wc),   64'(0));
    check("rst_wco",  64'(wco),  64'(0));
`ifdef JSERIAL_CMP_EN
    check("rst_weqo", 64'(weqo), 64'(0));
    check("rst_walo", 64'(walo), 64'(0));
`endif
    reset = 1'b0;
    tick();

    do_op("basic",   8'h5A, 8'h3C, 1'b0, 0);
    do_op("carry_ff", 8'hFF, 8'h01, 1'b0, 0);
    do_op("cin_only", 8'h00, 8'h00, 1'b1, 0);
    do_op("max_all", 8'hFF, 8'hFF, 1'b1, 0);
    do_op("cmp_gt",  8'h80, 8'h7F, 1'b0, 0);
    do_op("cmp_eq",  8'h3C, 8'h3C, 1'b0, 0);
    do_op("cmp_lt",  8'h01, 8'h02, 1'b0, 0);
    do_op("busy_start", 8'hA7, 8'h6E, 1'b1, 3);

    for (int unsigned k = 0; k < 20; k++)
      do_op($sformatf("rand%0d", k), N'($urandom), N'($urandom), 1'($urandom), 0);

    // Reset while idle after a completed op must clear the held result.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_idle_wc",  64'(wc),  64'(0));
    check("rst_idle_wco", 64'(wco), 64'(0));

    // Reset mid-operation.
    wa = 8'hC3; wb = 8'h5F; wci = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_wc",   64'(wc),   64'(0));
    check("abort_wco",  64'(wco),  64'(0));
    reset = 1'b0;
    extra = 0;
    for (int unsigned i = 0; i < 2 * N; i++) begin
      if (done || busy) extra++;
      tick();
    end
    check("abort_no_activity", 64'(extra), 64'(0));
    do_op("after_abort", 8'hC3, 8'h5F, 1'b1, 0);

    // Back-to-back with start held high through DONE.
    a1 = N'($urandom); b1 = N'($urandom); c1 = 1'($urandom);
    a2 = N'($urandom); b2 = N'($urandom); c2 = 1'($urandom);
    wa = a1; wb = b1; wci = c1; start = 1'b1;
    tick();
    wa = a2; wb = b2; wci = c2;
    wait_done(0, at, busy_n, early);
    check_timing("b2b_first", at, busy_n, early);
    check_result("b2b_first", a1, b1, c1);
    tick();
    start = 1'b0;
    check("b2b_busy_next", 64'(busy), 64'(1));
    check("b2b_done_next", 64'(done), 64'(0));
    wait_done(0, at, busy_n, early);
    check_timing("b2b_second", at, busy_n, early);
    check_result("b2b_second", a2, b2, c2);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jserial_add.md
JSERIAL_ADD -- requirements
Module: jserial_add

Interface
REQ-001 Parameter N, default 8: operand width in bits; legal range is 2..32.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port start, input, 1: request a new operation; sampled only in IDLE or DONE.
REQ-005 Port wa, input, N: operand A; sampled when start is accepted.
REQ-006 Port wb, input, N: operand B; sampled when start is accepted.
REQ-007 Port wci, input, 1: carry-in; sampled when start is accepted.
REQ-008 Port busy, output, 1: high while in RUN.
REQ-009 Port done, output, 1: high for exactly one cycle, in DONE.
REQ-010 Port wc, output, N: sum result.
REQ-011 Port wco, output, 1: carry-out.
REQ-012 Ports weqo and walo, output, 1 each: A==B and A>B (unsigned); present only when the macro in REQ-027 is defined.

Function
REQ-013 The block shall compute wa+wb+wci bit-serially, LSB first, through a single one-bit full-adder cell, one bit per clk cycle.
REQ-014 The FSM shall have three states: IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE after N bit-cycles.
- DONE->RUN on start, else DONE->IDLE.
REQ-015 On start acceptance, the block shall:
- latch wa and wb into shift registers;
- load the carry flop with wci;
- clear the bit counter and the result register.
REQ-016 Each RUN cycle shall:
- add the operand LSBs and the carry flop;
- shift the sum bit into the result MSB (right shift);
- store carry-out in the carry flop;
- increment the counter.
REQ-017 The counter shall be ceil(log2(N+1)) bits wide, and RUN shall exit when the counter reaches N-1 after that cycle's bit has been processed.
REQ-018 Latency: with start accepted at edge t, busy shall be high for cycles t+1..t+N and done shall be high in cycle t+N+1.
REQ-019 wc and wco shall change only on the final RUN edge and shall hold their values until the next accepted start clears them.
REQ-020 A start asserted while busy shall be ignored, with no effect on operands or results.
REQ-021 A start asserted in DONE shall be accepted, so back-to-back operations lose no cycle beyond DONE.
REQ-022 Arithmetic shall be unsigned modulo 2^N, and wco shall be the true carry out of bit N-1.

Reset
REQ-023 reset shall have priority over start and shall force the IDLE state.
REQ-024 Reset values: busy=0, done=0, wc=0, wco=0, weqo=0, walo=0; the counter, carry flop and shift registers shall be 0.
REQ-025 Reset asserted mid-RUN shall abort the operation, and done shall not be asserted for the aborted operation.
REQ-026 After reset deasserts, the first start shall be accepted normally.

Configuration
REQ-027 When macro JSERIAL_CMP_EN is defined, the block shall update two compare flops serially, LSB first, on every RUN cycle:
- eq is initialised to 1 and updated as eq AND NOT(a_i XOR b_i);
- gt is initialised to 0 and, when a_i XOR b_i, updated to a_i;
- weqo/walo shall take the final values together with wc.
REQ-028 When JSERIAL_CMP_EN is undefined, the weqo/walo ports and the compare logic shall be absent, and the adder behaviour shall be unchanged.

Structure
REQ-029 The FSM state encodings (IDLE=0, RUN=1, DONE=2) and the state width shall be defined in the shared defs file, not locally.
REQ-030 The per-bit add shall instantiate the existing gate-level full-adder cell (jadd).
REQ-031 There shall be no other sub-module; the counter, FSM and shifters shall be local.

Verification (N=8)
REQ-032 Basic add: wa=8'h5A, wb=8'h3C, wci=0, start one cycle -> busy cycles 1..8, done in cycle 9, wc=8'h96, wco=0.
REQ-033 Carry propagation: wa=8'hFF, wb=8'h01, wci=0 -> wc=8'h00, wco=1; wa=0, wb=0, wci=1 -> wc=8'h01, wco=0.
REQ-034 Start while busy: start at t, changed operands with start at t+3 -> the result is from the first operands only, and exactly one done pulse occurs.
REQ-035 Reset mid-op: reset in cycle t+4 -> IDLE with all outputs 0, no done pulse; a new start then gives the correct result.
REQ-036 Back-to-back: start held high through DONE -> the second operation's busy begins in the cycle after done, and both results are correct.
REQ-037 With JSERIAL_CMP_EN defined: 8'h80 vs 8'h7F -> weqo=0, walo=1; 8'h3C vs 8'h3C -> weqo=1, walo=0; 8'h01 vs 8'h02 -> weqo=0, walo=0.
